// File: rtl/lifo_arbiter.sv
// lifo_arbiter: two-client round-robin arbiter in front of a single LIFO.
// Tracks LIFO occupancy, rejects push-when-full / pop-when-empty, returns
// one-cycle response strobes, and sequences LIFO reset/flush via an FSM.
// Optional feature: define LIFO_ARBITER_ERR_CNT_EN to enable the saturating
// rejected-request counter on err_cnt_o (tied to zero otherwise).
module lifo_arbiter #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              flush_i,
    input  logic              c0_req_valid_i,
    input  logic              c0_req_write_i,
    input  logic [DWIDTH-1:0] c0_req_data_i,
    output logic              c0_req_ready_o,
    output logic              c0_rsp_valid_o,
    output logic [DWIDTH-1:0] c0_rsp_data_o,
    output logic              c0_rsp_err_o,
    input  logic              c1_req_valid_i,
    input  logic              c1_req_write_i,
    input  logic [DWIDTH-1:0] c1_req_data_i,
    output logic              c1_req_ready_o,
    output logic              c1_rsp_valid_o,
    output logic [DWIDTH-1:0] c1_rsp_data_o,
    output logic              c1_rsp_err_o,
    output logic              lifo_srst_o,
    output logic              lifo_wrreq_o,
    output logic              lifo_rdreq_o,
    output logic [DWIDTH-1:0] lifo_data_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    output logic [AWIDTH:0]   usedw_o,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Occupancy value meaning "LIFO full" (2**AWIDTH).
    localparam logic [AWIDTH:0] USEDW_FULL = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] USEDW_ONE  = {{AWIDTH{1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              last_r;        // 1: client 1 was granted last
    logic [AWIDTH:0]   usedw_r;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              any_gnt_s;
    logic              sel_write_s;
    logic [DWIDTH-1:0] sel_data_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              reject_s;
    logic              rsp_valid0_r;
    logic              rsp_valid1_r;
    logic              rsp_err0_r;
    logic              rsp_err1_r;
    logic              rsp_pop0_r;
    logic              rsp_pop1_r;

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: INIT and FLUSH each last one cycle, flush_i leaves RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT:  state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (flush_i) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // Round-robin grant: only in RUN without flush; ties go to the client not served last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_r == ST_RUN) && !flush_i) begin
            if (c0_req_valid_i && c1_req_valid_i) begin
                if (last_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else begin
                gnt0_s = c0_req_valid_i;
                gnt1_s = c1_req_valid_i;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Decode the granted request into a LIFO push, pop or rejection.
    always_comb begin
        any_gnt_s = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            sel_write_s = c1_req_write_i;
            sel_data_s  = c1_req_data_i;
        end else begin
            sel_write_s = c0_req_write_i;
            sel_data_s  = c0_req_data_i;
        end
        push_ok_s = any_gnt_s &  sel_write_s & (usedw_r != USEDW_FULL);
        pop_ok_s  = any_gnt_s & ~sel_write_s & (usedw_r != {(AWIDTH+1){1'b0}});
        reject_s  = any_gnt_s & ~push_ok_s & ~pop_ok_s;
    end

    // Round-robin pointer moves only when a grant is issued.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_r <= 1'b1;
        end else if (gnt0_s) begin
            last_r <= 1'b0;
        end else if (gnt1_s) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end

    // Occupancy tracking; cleared whenever the LIFO is being reset or flushed.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            usedw_r <= {(AWIDTH+1){1'b0}};
        end else if ((state_r != ST_RUN) || flush_i) begin
            usedw_r <= {(AWIDTH+1){1'b0}};
        end else if (push_ok_s) begin
            usedw_r <= usedw_r + USEDW_ONE;
        end else if (pop_ok_s) begin
            usedw_r <= usedw_r - USEDW_ONE;
        end else begin
            usedw_r <= usedw_r;
        end
    end

    // Response strobes one cycle after a grant; kept through a flush, dropped by reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rsp_valid0_r <= 1'b0;
            rsp_valid1_r <= 1'b0;
            rsp_err0_r   <= 1'b0;
            rsp_err1_r   <= 1'b0;
            rsp_pop0_r   <= 1'b0;
            rsp_pop1_r   <= 1'b0;
        end else begin
            rsp_valid0_r <= gnt0_s;
            rsp_valid1_r <= gnt1_s;
            rsp_err0_r   <= gnt0_s & reject_s;
            rsp_err1_r   <= gnt1_s & reject_s;
            rsp_pop0_r   <= gnt0_s & pop_ok_s;
            rsp_pop1_r   <= gnt1_s & pop_ok_s;
        end
    end

`ifdef LIFO_ARBITER_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of rejected requests; cleared only by reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_cnt_r <= 8'h00;
        end else if (reject_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt_o = err_cnt_r;
`else
    assign err_cnt_o = 8'h00;
`endif

    assign c0_req_ready_o = gnt0_s;
    assign c1_req_ready_o = gnt1_s;
    assign c0_rsp_valid_o = rsp_valid0_r;
    assign c1_rsp_valid_o = rsp_valid1_r;
    assign c0_rsp_err_o   = rsp_err0_r;
    assign c1_rsp_err_o   = rsp_err1_r;
    // LIFO read data arrives in the response cycle, so it is steered, not registered.
    assign c0_rsp_data_o  = rsp_pop0_r ? lifo_q_i : {DWIDTH{1'b0}};
    assign c1_rsp_data_o  = rsp_pop1_r ? lifo_q_i : {DWIDTH{1'b0}};
    assign lifo_srst_o    = (state_r != ST_RUN);
    assign lifo_wrreq_o   = push_ok_s;
    assign lifo_rdreq_o   = pop_ok_s;
    assign lifo_data_o    = push_ok_s ? sel_data_s : {DWIDTH{1'b0}};
    assign usedw_o        = usedw_r;

endmodule

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8, data word width; SHALL match the attached LIFO.
REQ-002 Parameter AWIDTH, default 4, LIFO address width; LIFO depth is 2**AWIDTH.
REQ-003 clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 arst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 flush_i  in  1  request to empty the LIFO.
REQ-006 cN_req_valid_i  in  1  client N request (N=0,1); SHALL NOT depend on cN_req_ready_o.
REQ-007 cN_req_write_i  in  1  1=push, 0=pop; qualified by cN_req_valid_i.
REQ-008 cN_req_data_i  in  DWIDTH  push data.
REQ-009 cN_req_ready_o  out  1  grant; transfer occurs when valid and ready are both 1.
REQ-010 cN_rsp_valid_o  out  1  one-cycle response strobe.
REQ-011 cN_rsp_data_o  out  DWIDTH  popped data; 0 for push or error.
REQ-012 cN_rsp_err_o  out  1  push-when-full or pop-when-empty rejected.
REQ-013 lifo_srst_o  out  1  synchronous reset to the LIFO.
REQ-014 lifo_wrreq_o / lifo_rdreq_o  out  1 each  LIFO push and pop strobes.
REQ-015 lifo_data_o  out  DWIDTH  push data; lifo_q_i  in  DWIDTH  LIFO read data, valid one cycle after lifo_rdreq_o.
REQ-016 usedw_o  out  AWIDTH+1  arbiter-tracked occupancy; err_cnt_o  out  8  rejected-request count.

Function
REQ-017 FSM states INIT, RUN, FLUSH; INIT->RUN after 1 cycle; RUN->FLUSH when flush_i=1; FLUSH->RUN after 1 cycle.
REQ-018 In INIT and FLUSH, lifo_srst_o=1, no grants are issued, and usedw_o is 0 at the end of the cycle.
REQ-019 In RUN, a cycle with flush_i=1 issues no grant.
REQ-020 In RUN, at most one grant per cycle; cN_req_ready_o is combinational from the valids and the round-robin pointer.
REQ-021 Round-robin: with both valids high, the grant goes to the client not granted last; a lone valid is granted immediately.
REQ-022 Pointer updates only on a grant.
REQ-023 Push grant with usedw_o<2**AWIDTH drives lifo_wrreq_o=1 and lifo_data_o=cN_req_data_i in the grant cycle; usedw_o increments.
REQ-024 Pop grant with usedw_o>0 drives lifo_rdreq_o=1 in the grant cycle; usedw_o decrements.
REQ-025 lifo_wrreq_o and lifo_rdreq_o are never 1 in the same cycle.
REQ-026 A push at usedw_o=2**AWIDTH or a pop at usedw_o=0 is still granted but rejected.
REQ-027 A rejected request produces no LIFO strobe and no change to usedw_o.
REQ-028 The granted client's cN_rsp_valid_o is 1 exactly one cycle after its grant, with cN_rsp_err_o set per REQ-026.
REQ-029 For a successful pop, cN_rsp_data_o is lifo_q_i in the response cycle; otherwise cN_rsp_data_o is 0.
REQ-030 A response due in the cycle after a grant is delivered even if the FSM has entered FLUSH.
REQ-031 usedw_o is never outside 0..2**AWIDTH.

Reset
REQ-032 While arst_n_i=0, outputs are held at reset values.
REQ-033 Reset values: state INIT, usedw_o=0, round-robin pointer "last=client 1", all rsp_valid/err/data=0, err_cnt_o=0.
REQ-034 On reset release, lifo_srst_o=1 for exactly one cycle (INIT).
REQ-035 Assertion mid-operation discards any pending response.

Configuration
REQ-036 With macro LIFO_ARBITER_ERR_CNT_EN defined, err_cnt_o increments on each rejected request, saturates at 255, and clears only on reset.
REQ-037 Without LIFO_ARBITER_ERR_CNT_EN, err_cnt_o is tied to 0 and no counter logic is present; all other behaviour is identical.

Verification
REQ-038 Reset release -> lifo_srst_o=1 for 1 cycle, then c0 push 0xA5 granted; lifo_wrreq_o=1, c0_rsp_valid_o=1 next cycle with err=0, usedw_o=1.
REQ-039 Both clients pushing continuously for 6 cycles -> grants alternate c0,c1,c0,... and usedw_o=6.
REQ-040 Push 0x11,0x22,0x33, then pop three times -> rsp_data 0x33,0x22,0x11; usedw_o=0.
REQ-041 16 pushes, a 17th push, then a pop on empty after draining -> both rejects have rsp_err=1, no LIFO strobes, err_cnt_o=2 (0 without macro).
REQ-042 flush_i for 1 cycle at usedw_o=5 -> lifo_srst_o=1 next cycle, no grants, usedw_o=0, then a pop returns err=1.
REQ-043 arst_n_i asserted the cycle after a pop grant -> no rsp_valid, usedw_o=0, INIT repeats on release.
